// File: rtl/xor_begin_perm_ctrl.sv
// -----------------------------------------------------------------------------
// xor_begin_perm_ctrl
//
// Begin-of-permutation injection stage for the ASCON-128 datapath. It accepts
// the state coming back from the permutation, waits for the next 64-bit data
// block and applies the phase-dependent XORs before handing the state back:
//   mode 00 (init)          : state passes through unchanged, no data consumed
//   mode 01 (assoc. data)   : x0 ^= data
//   mode 10 (plaintext)     : x0 ^= data, ciphertext = new x0 is emitted
//   mode 11 (finalization)  : x0 ^= data, {x1,x2} ^= key, ciphertext emitted
//
// State word packing (320 bits): x0 = [319:256], x1 = [255:192],
// x2 = [191:128], x3 = [127:64], x4 = [63:0].
//
// Ports
//   clock_i, reset_i      rising-edge clock, synchronous active-high reset
//   mode_i                phase, sampled together with state_i
//   state_i/_valid_i      incoming state, state_ready_o back-pressure
//   data_i/_valid_i       data block, data_ready_o back-pressure
//   key_i                 128-bit key, used at the data handshake in mode 11
//   state_o/_valid_o      updated state, state_ready_i back-pressure
//   cipher_o/_valid_o     ciphertext block with one-cycle strobe
//   block_cnt_o           data blocks absorbed since reset, wraps at 256
//                         (present only when XOR_BEGIN_BLOCK_CNT_EN is defined)
// -----------------------------------------------------------------------------
module xor_begin_perm_ctrl (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic [1:0]   mode_i,
  input  logic [319:0] state_i,
  input  logic         state_valid_i,
  output logic         state_ready_o,
  input  logic [63:0]  data_i,
  input  logic         data_valid_i,
  output logic         data_ready_o,
  input  logic [127:0] key_i,
  output logic [319:0] state_o,
  output logic         state_valid_o,
  input  logic         state_ready_i,
  output logic [63:0]  cipher_o,
  output logic         cipher_valid_o
`ifdef XOR_BEGIN_BLOCK_CNT_EN
  ,
  output logic [7:0]   block_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    OUT       = 2'd2
  } fsm_t;

  fsm_t       fsm;
  logic [1:0] mode_q;

  // Phase-dependent injection into the captured state.
  function automatic logic [319:0] inject(input logic [319:0] st,
                                          input logic [63:0]  d,
                                          input logic [127:0] k,
                                          input logic [1:0]   m);
    logic [319:0] r;
    r = st;
    r[319:256] = st[319:256] ^ d;
    if (m == 2'b11) begin
      r[255:128] = st[255:128] ^ k;
    end
    return r;
  endfunction

  // All outputs are registers, so ready signals never depend on inputs
  // combinationally.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm            <= IDLE;
      mode_q         <= 2'b00;
      state_ready_o  <= 1'b1;
      data_ready_o   <= 1'b0;
      state_valid_o  <= 1'b0;
      cipher_valid_o <= 1'b0;
      state_o        <= '0;
      cipher_o       <= '0;
`ifdef XOR_BEGIN_BLOCK_CNT_EN
      block_cnt_o    <= 8'd0;
`endif
    end else begin
      // The cipher strobe is a single cycle even when OUT stalls.
      cipher_valid_o <= 1'b0;
      case (fsm)
        IDLE: begin
          if (state_valid_i) begin
            state_o       <= state_i;
            mode_q        <= mode_i;
            state_ready_o <= 1'b0;
            if (mode_i == 2'b00) begin
              fsm           <= OUT;
              state_valid_o <= 1'b1;
            end else begin
              fsm          <= WAIT_DATA;
              data_ready_o <= 1'b1;
            end
          end
        end
        WAIT_DATA: begin
          if (data_valid_i) begin
            state_o       <= inject(state_o, data_i, key_i, mode_q);
            data_ready_o  <= 1'b0;
            state_valid_o <= 1'b1;
            fsm           <= OUT;
            if (mode_q[1]) begin
              cipher_o       <= state_o[319:256] ^ data_i;
              cipher_valid_o <= 1'b1;
            end
`ifdef XOR_BEGIN_BLOCK_CNT_EN
            block_cnt_o <= block_cnt_o + 8'd1;
`endif
          end
        end
        OUT: begin
          if (state_ready_i) begin
            state_valid_o <= 1'b0;
            state_ready_o <= 1'b1;
            fsm           <= IDLE;
          end
        end
        default: begin
          fsm           <= IDLE;
          state_ready_o <= 1'b1;
          data_ready_o  <= 1'b0;
          state_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_begin_perm_ctrl.sv
module tb_xor_begin_perm_ctrl;

  logic         clock_i = 1'b0;
  logic         reset_i;
  logic [1:0]   mode_i;
  logic [319:0] state_i;
  logic         state_valid_i;
  logic         state_ready_o;
  logic [63:0]  data_i;
  logic         data_valid_i;
  logic         data_ready_o;
  logic [127:0] key_i;
  logic [319:0] state_o;
  logic         state_valid_o;
  logic         state_ready_i;
  logic [63:0]  cipher_o;
  logic         cipher_valid_o;
`ifdef XOR_BEGIN_BLOCK_CNT_EN
  logic [7:0]   block_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;   // reference count of absorbed blocks (mod 256)

  xor_begin_perm_ctrl dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .mode_i         (mode_i),
    .state_i        (state_i),
    .state_valid_i  (state_valid_i),
    .state_ready_o  (state_ready_o),
    .data_i         (data_i),
    .data_valid_i   (data_valid_i),
    .data_ready_o   (data_ready_o),
    .key_i          (key_i),
    .state_o        (state_o),
    .state_valid_o  (state_valid_o),
    .state_ready_i  (state_ready_i),
    .cipher_o       (cipher_o),
    .cipher_valid_o (cipher_valid_o)
`ifdef XOR_BEGIN_BLOCK_CNT_EN
    ,
    .block_cnt_o    (block_cnt_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [319:0] rnd320();
    return {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
  endfunction

  task automatic check_cnt(input string name);
`ifdef XOR_BEGIN_BLOCK_CNT_EN
    n_cmp++;
    if (block_cnt_o !== 8'(exp_cnt)) begin
      n_err++;
      $display("FAIL %s block_cnt: got %0d expected %0d", name, block_cnt_o, exp_cnt % 256);
    end
`endif
  endtask

  // One complete transaction: state in, optional data, optional OUT stall,
  // OUT exit. Expected values come from the word-level phase rules.
  task automatic txn(input logic [1:0] m, input logic [319:0] st,
                     input logic [63:0] d, input logic [127:0] k,
                     input int stall, input int data_gap,
                     output logic [319:0] got_st, output logic [63:0] got_c);
    logic [63:0]  w [5];
    logic [319:0] exp_st;
    logic [63:0]  exp_c;
    logic         exp_strobe;
    int           guard;
    for (int i = 0; i < 5; i++) w[i] = st[319 - 64*i -: 64];
    if (m != 2'b00) w[0] = w[0] ^ d;
    if (m == 2'b11) begin
      w[1] = w[1] ^ k[127:64];
      w[2] = w[2] ^ k[63:0];
    end
    exp_st     = {w[0], w[1], w[2], w[3], w[4]};
    exp_c      = w[0];
    exp_strobe = m[1];
    got_st     = '0;
    got_c      = '0;

    guard = 0;
    while (state_ready_o !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    n_cmp++;
    if (state_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL txn_wait_state_ready: got %b expected 1", state_ready_o);
      return;
    end

    mode_i        = m;
    state_i       = st;
    state_valid_i = 1'b1;
    step();
    state_valid_i = 1'b0;
    state_i       = rnd320();
    mode_i        = 2'($urandom);
    n_cmp++;
    if (state_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL state_ready_after_accept: got %b expected 0", state_ready_o);
    end

    if (m != 2'b00) begin
      for (int g = 0; g < data_gap; g++) begin
        n_cmp++;
        if (data_ready_o !== 1'b1 || state_valid_o !== 1'b0) begin
          n_err++;
          $display("FAIL wait_data_hold: got rdy=%b vld=%b expected rdy=1 vld=0",
                   data_ready_o, state_valid_o);
        end
        step();
      end
      n_cmp++;
      if (data_ready_o !== 1'b1) begin
        n_err++;
        $display("FAIL data_ready: got %b expected 1", data_ready_o);
      end
      data_i       = d;
      key_i        = k;
      data_valid_i = 1'b1;
      step();
      data_valid_i = 1'b0;
      data_i       = rnd64();
      key_i        = {rnd64(), rnd64()};
      exp_cnt      = (exp_cnt + 1) % 256;
      n_cmp++;
      if (data_ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL data_ready_after_accept: got %b expected 0", data_ready_o);
      end
    end

    // First OUT cycle.
    got_st = state_o;
    got_c  = cipher_o;
    n_cmp++;
    if (state_valid_o !== 1'b1 || state_o !== exp_st) begin
      n_err++;
      $display("FAIL state_out mode=%0d: got vld=%b %h expected vld=1 %h",
               m, state_valid_o, state_o, exp_st);
    end
    n_cmp++;
    if (cipher_valid_o !== exp_strobe) begin
      n_err++;
      $display("FAIL cipher_strobe mode=%0d: got %b expected %b", m, cipher_valid_o, exp_strobe);
    end
    if (exp_strobe) begin
      n_cmp++;
      if (cipher_o !== exp_c) begin
        n_err++;
        $display("FAIL cipher_value: got %h expected %h", cipher_o, exp_c);
      end
    end
    check_cnt("after_data");

    // Stall in OUT with stray traffic on both input handshakes.
    state_ready_i = 1'b0;
    for (int s = 0; s < stall; s++) begin
      data_valid_i  = 1'b1;
      state_valid_i = 1'b1;
      step();
      n_cmp++;
      if (state_o !== exp_st || state_valid_o !== 1'b1 || state_ready_o !== 1'b0 ||
          data_ready_o !== 1'b0 || cipher_valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL out_stall: got vld=%b srdy=%b drdy=%b cv=%b st=%h expected 1 0 0 0 %h",
                 state_valid_o, state_ready_o, data_ready_o, cipher_valid_o, state_o, exp_st);
      end
    end
    data_valid_i  = 1'b0;
    state_valid_i = 1'b0;
    if (stall > 0) check_cnt("after_stall");

    state_ready_i = 1'b1;
    step();
    state_ready_i = 1'b0;
    n_cmp++;
    if (state_ready_o !== 1'b1 || state_valid_o !== 1'b0 || cipher_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL out_exit: got srdy=%b vld=%b cv=%b expected 1 0 0",
               state_ready_o, state_valid_o, cipher_valid_o);
    end
  endtask

  task automatic test_reset();
    reset_i       = 1'b1;
    state_valid_i = 1'b1;
    state_i       = rnd320();
    mode_i        = 2'b00;
    data_valid_i  = 1'b1;
    step();
    step();
    reset_i       = 1'b0;
    state_valid_i = 1'b0;
    data_valid_i  = 1'b0;
    exp_cnt       = 0;
    n_cmp++;
    if (state_o !== '0 || cipher_o !== '0 || state_valid_o !== 1'b0 ||
        cipher_valid_o !== 1'b0 || data_ready_o !== 1'b0 || state_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_values: got st=%h c=%h sv=%b cv=%b dr=%b sr=%b expected 0 0 0 0 0 1",
               state_o, cipher_o, state_valid_o, cipher_valid_o, data_ready_o, state_ready_o);
    end
    check_cnt("reset");
    step();
    n_cmp++;
    if (state_ready_o !== 1'b1 || state_valid_o !== 1'b0 || state_o !== '0) begin
      n_err++;
      $display("FAIL reset_nothing_captured: got sr=%b sv=%b st=%h expected 1 0 0",
               state_ready_o, state_valid_o, state_o);
    end
  endtask

  task automatic test_init();
    logic [319:0] gs; logic [63:0] gc;
    txn(2'b00, {64'd1, 64'd2, 64'd3, 64'd4, 64'd5}, rnd64(), {rnd64(), rnd64()}, 0, 0, gs, gc);
    n_cmp++;
    if (gs !== {64'd1, 64'd2, 64'd3, 64'd4, 64'd5}) begin
      n_err++;
      $display("FAIL init_passthrough: got %h", gs);
    end
  endtask

  task automatic test_ad();
    logic [319:0] gs; logic [63:0] gc;
    txn(2'b01, {64'hFFFF_0000_FFFF_0000, 64'h11, 64'h22, 64'h33, 64'h44},
        64'h0F0F_0F0F_0F0F_0F0F, {rnd64(), rnd64()}, 0, 2, gs, gc);
    n_cmp++;
    if (gs !== {64'hF0F0_0F0F_F0F0_0F0F, 64'h11, 64'h22, 64'h33, 64'h44}) begin
      n_err++;
      $display("FAIL ad_absorb: got %h", gs);
    end
  endtask

  task automatic test_plaintext();
    logic [319:0] gs; logic [63:0] gc;
    txn(2'b10, {64'h0123_4567_89AB_CDEF, rnd64(), rnd64(), rnd64(), rnd64()},
        64'hFFFF_FFFF_FFFF_FFFF, {rnd64(), rnd64()}, 0, 0, gs, gc);
    n_cmp++;
    if (gc !== 64'hFEDC_BA98_7654_3210 || gs[319:256] !== 64'hFEDC_BA98_7654_3210) begin
      n_err++;
      $display("FAIL plaintext_cipher: got c=%h x0=%h expected FEDCBA9876543210", gc, gs[319:256]);
    end
  endtask

  task automatic test_finalization();
    logic [319:0] gs; logic [63:0] gc;
    txn(2'b11, {rnd64(), 64'd0, 64'd0, rnd64(), rnd64()}, rnd64(),
        128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F, 0, 1, gs, gc);
    n_cmp++;
    if (gs[255:192] !== 64'h0001_0203_0405_0607 || gs[191:128] !== 64'h0809_0A0B_0C0D_0E0F) begin
      n_err++;
      $display("FAIL final_key: got x1=%h x2=%h", gs[255:192], gs[191:128]);
    end
  endtask

  task automatic test_backpressure();
    logic [319:0] gs; logic [63:0] gc;
    txn(2'b10, rnd320(), rnd64(), {rnd64(), rnd64()}, 5, 0, gs, gc);
    txn(2'b00, rnd320(), rnd64(), {rnd64(), rnd64()}, 5, 0, gs, gc);
  endtask

  task automatic test_idle_data_ignored();
    data_valid_i = 1'b1;
    data_i       = rnd64();
    step();
    step();
    data_valid_i = 1'b0;
    n_cmp++;
    if (data_ready_o !== 1'b0 || state_ready_o !== 1'b1 || state_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL idle_data_ignored: got dr=%b sr=%b sv=%b expected 0 1 0",
               data_ready_o, state_ready_o, state_valid_o);
    end
    check_cnt("idle_data");
  endtask

  task automatic test_reset_midop();
    mode_i        = 2'b10;
    state_i       = rnd320();
    state_valid_i = 1'b1;
    step();
    state_valid_i = 1'b0;
    reset_i       = 1'b1;
    data_valid_i  = 1'b1;
    data_i        = rnd64();
    step();
    reset_i       = 1'b0;
    data_valid_i  = 1'b0;
    exp_cnt       = 0;
    n_cmp++;
    if (cipher_valid_o !== 1'b0 || state_valid_o !== 1'b0 || state_o !== '0 ||
        state_ready_o !== 1'b1 || data_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midop: got cv=%b sv=%b sr=%b dr=%b st=%h expected 0 0 1 0 0",
               cipher_valid_o, state_valid_o, state_ready_o, data_ready_o, state_o);
    end
    check_cnt("reset_midop");
  endtask

  task automatic test_random();
    logic [319:0] gs; logic [63:0] gc;
    for (int i = 0; i < 40; i++) begin
      txn(2'($urandom), rnd320(), rnd64(), {rnd64(), rnd64()},
          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), gs, gc);
    end
  endtask

  task automatic test_back_to_back();
    logic [319:0] gs; logic [63:0] gc;
    for (int i = 0; i < 8; i++) begin
      txn(2'(i % 4), rnd320(), rnd64(), {rnd64(), rnd64()}, 0, 0, gs, gc);
    end
  endtask

  task automatic test_counter_wrap();
`ifdef XOR_BEGIN_BLOCK_CNT_EN
    logic [319:0] gs; logic [63:0] gc;
    for (int i = 0; i < 256; i++) begin
      txn(2'b01, rnd320(), rnd64(), {rnd64(), rnd64()}, 0, 0, gs, gc);
    end
    check_cnt("wrap");
`endif
  endtask

  initial begin
    reset_i       = 1'b1;
    mode_i        = 2'b00;
    state_i       = '0;
    state_valid_i = 1'b0;
    data_i        = '0;
    data_valid_i  = 1'b0;
    key_i         = '0;
    state_ready_i = 1'b0;
    #1;
    test_reset();
    test_init();
    test_ad();
    test_plaintext();
    test_finalization();
    test_backpressure();
    test_idle_data_ignored();
    test_random();
    test_back_to_back();
    test_reset_midop();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
